// File: rtl/dspl_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver.
// Optional blink feature is enabled with DSPL_BLINK_EN.
package dspl_pkg;

    localparam int DIGIT_W = 6;
    localparam int EN_POS  = 5;
    localparam int CODE_HI = 4;
    localparam int CODE_LO = 1;
    localparam int DP_POS  = 0;

    typedef struct packed {
        logic       en;
        logic [3:0] code;
        logic       dp;
    } digit_t;

    // abcdefg, active low; A-C are single bars, D-F are d/E/F glyphs
    localparam logic [6:0] SEG_LUT [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b1110111, 7'b1111110,
        7'b0111111, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        return SEG_LUT[code];
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dspl_scan_drv_if.sv
// Digit/brightness inputs and anode/cathode outputs of the scan driver.
// blink_mask exists only when DSPL_BLINK_EN is defined.
interface dspl_scan_drv_if #(
    parameter int N_DIGITS = 8,
    parameter int BRIGHT_W = 4
);

    logic [6*N_DIGITS-1:0] digits;
    logic [BRIGHT_W-1:0]   brightness;
`ifdef DSPL_BLINK_EN
    logic [N_DIGITS-1:0]   blink_mask;
`endif
    logic [N_DIGITS-1:0]   an;
    logic [7:0]            dec_cat;
    logic                  frame_start;

    modport master (
`ifdef DSPL_BLINK_EN
        output blink_mask,
`endif
        output digits,
        output brightness,
        input  an,
        input  dec_cat,
        input  frame_start
    );

    modport slave (
`ifdef DSPL_BLINK_EN
        input  blink_mask,
`endif
        input  digits,
        input  brightness,
        output an,
        output dec_cat,
        output frame_start
    );

endinterface

// File: rtl/dspl_scan_timer.sv
// Slot tick counter and digit index for the scan driver, with
// slot-wrap and frame-start strobes (blink option: DSPL_BLINK_EN, top level).
module dspl_scan_timer
    import dspl_pkg::*;
#(
    parameter int N_DIGITS  = 8,
    parameter int SLOT_LOG2 = 17,
    parameter int IDX_W     = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic [SLOT_LOG2-1:0] tick_cnt,
    output logic [IDX_W-1:0]     idx,
    output logic [IDX_W-1:0]     idx_next,
    output logic                 slot_wrap,
    output logic                 frame_strobe
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    assign slot_wrap    = &tick_cnt;
    assign idx_next     = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    assign frame_strobe = (tick_cnt == '0) && (idx == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            tick_cnt <= '0;
            idx      <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
            if (slot_wrap) begin
                idx <= idx_next;
            end
        end
    end

endmodule

// File: rtl/dspl_scan_drv.sv
// Multiplexed 7-segment scan driver: per-slot snapshot, PWM with dead time,
// registered outputs. Define DSPL_BLINK_EN to add per-digit blinking.
module dspl_scan_drv
    import dspl_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int SLOT_LOG2    = 17,
    parameter int BRIGHT_W     = 4,
    parameter int DEAD_CYCLES  = 16,
    parameter int BLINK_FRAMES = 48
) (
    input  logic           clock,
    input  logic           reset,
    dspl_scan_drv_if.slave bus
);

    localparam int IDX_W = idx_width(N_DIGITS);

    logic [SLOT_LOG2-1:0] tick_cnt;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     idx_next;
    logic                 slot_wrap;
    logic                 frame_strobe;

    dspl_scan_timer #(
        .N_DIGITS (N_DIGITS),
        .SLOT_LOG2(SLOT_LOG2),
        .IDX_W    (IDX_W)
    ) u_timer (
        .clock       (clock),
        .reset       (reset),
        .tick_cnt    (tick_cnt),
        .idx         (idx),
        .idx_next    (idx_next),
        .slot_wrap   (slot_wrap),
        .frame_strobe(frame_strobe)
    );

    digit_t              digit_sel;
    digit_t              snap;
    logic [BRIGHT_W-1:0] bright_q;
    logic                blink_sel;
    logic                suppress;

    always_comb begin
        digit_sel = '0;
        blink_sel = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_next == IDX_W'(i)) begin
                digit_sel = bus.digits[DIGIT_W*i +: DIGIT_W];
`ifdef DSPL_BLINK_EN
                blink_sel = bus.blink_mask[i];
`endif
            end
        end
    end

    // Snapshot is taken only at slot boundaries so inputs never glitch a slot
    always_ff @(posedge clock) begin
        if (reset) begin
            snap     <= '0;
            bright_q <= '0;
        end else if (slot_wrap) begin
            snap     <= digit_sel;
            bright_q <= bus.brightness;
        end
    end

`ifdef DSPL_BLINK_EN
    localparam int BF_W = idx_width(BLINK_FRAMES);
    localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);

    logic [BF_W-1:0] frame_cnt;
    logic            phase;
    logic            snap_blink;

    // Frames are counted at slot wraps into digit 0, not at the reset start
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_cnt  <= '0;
            phase      <= 1'b0;
            snap_blink <= 1'b0;
        end else if (slot_wrap) begin
            snap_blink <= blink_sel;
            if (idx_next == '0) begin
                if (frame_cnt == BF_LAST) begin
                    frame_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    assign suppress = phase & snap_blink;
`else
    assign suppress = 1'b0;
`endif

    logic                pwm_on;
    logic                past_dead;
    logic                lit;
    logic [N_DIGITS-1:0] an_next;

    assign pwm_on    = tick_cnt[SLOT_LOG2-1 -: BRIGHT_W] <= bright_q;
    assign past_dead = tick_cnt >= SLOT_LOG2'(DEAD_CYCLES);
    assign lit       = snap.en & pwm_on & past_dead & ~suppress;

    always_comb begin
        an_next = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                an_next[i] = ~lit;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.an          <= '1;
            bus.dec_cat     <= 8'hFF;
            bus.frame_start <= 1'b0;
        end else begin
            bus.an          <= an_next;
            bus.dec_cat     <= {seg_decode(snap.code), ~snap.dp};
            bus.frame_start <= frame_strobe;
        end
    end

endmodule
